// File: rtl/mem_stage.sv
// MEM stage of the 5-stage LoongArch pipeline: holds one instruction, waits for the
// data-SRAM response when needed, aligns/extends load data and hands off to WB.
module mem_stage #(
  parameter int EXE_BUS_W = 176,
  parameter int MEM_BUS_W = 168
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 exe_valid,
  input  logic                 exe_ready_go,
  input  logic [EXE_BUS_W-1:0] exe_bus,
  output logic                 mem_allow_in,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 wb_allow_in,
  input  logic                 flush,
  output logic                 mem_to_wb_valid,
  output logic                 mem_ready_go,
  output logic [MEM_BUS_W-1:0] mem_bus,
  output logic [39:0]          mem_bypass_bus,
  output logic                 mem_ex
);

  typedef struct packed {
    logic [15:0] ebus;
    logic        ertn;
    logic [79:0] csr_ctrl;
    logic        res_from_csr;
    logic        mem_req;
    logic [4:0]  ld_op;      // {w,hu,h,bu,b}
    logic [1:0]  addr_lo;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } exe_pl_t;

  exe_pl_t     pl;
  logic        valid, rbuf_valid, discard;
  logic [31:0] rbuf;
  logic        need_data, fresh_ok, load_in, leave;
  logic [31:0] data, shifted, final_result;
  logic [15:0] half;

  assign need_data       = valid & pl.mem_req & ~(|pl.ebus);
  assign fresh_ok        = data_sram_data_ok & ~discard;
  assign mem_ready_go    = ~need_data | fresh_ok | rbuf_valid;
  assign mem_allow_in    = ~valid | (mem_ready_go & wb_allow_in);
  assign mem_to_wb_valid = valid & mem_ready_go & ~flush;
  assign load_in         = exe_valid & exe_ready_go & mem_allow_in & ~flush;
  assign leave           = valid & mem_ready_go & wb_allow_in;
  assign mem_ex          = valid & ((|pl.ebus) | pl.ertn);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid      <= 1'b0;
      pl         <= '0;
      rbuf       <= '0;
      rbuf_valid <= 1'b0;
      discard    <= 1'b0;
    end else begin
      if (flush)        valid <= 1'b0;
      else if (load_in) valid <= 1'b1;
      else if (leave)   valid <= 1'b0;

      if (load_in) pl <= exe_pl_t'(exe_bus);

      // Park a response that arrives while WB is stalled so the SRAM need not hold it.
      if (fresh_ok & need_data & ~wb_allow_in & ~rbuf_valid) rbuf <= data_sram_rdata;
      if (flush | leave)
        rbuf_valid <= 1'b0;
      else if (fresh_ok & need_data & ~wb_allow_in)
        rbuf_valid <= 1'b1;

      // A killed instruction's request is still in flight; swallow its response.
      if (flush & need_data & ~fresh_ok & ~rbuf_valid)
        discard <= 1'b1;
      else if (data_sram_data_ok & discard)
        discard <= 1'b0;
    end
  end

  assign data    = rbuf_valid ? rbuf : data_sram_rdata;
  assign shifted = data >> {pl.addr_lo, 3'b000};
  assign half    = pl.addr_lo[1] ? data[31:16] : data[15:0];

  always_comb begin
    final_result = pl.alu_result;
    if (pl.ld_op[4])      final_result = data;
    else if (pl.ld_op[3]) final_result = {16'h0, half};
    else if (pl.ld_op[2]) final_result = {{16{half[15]}}, half};
    else if (pl.ld_op[1]) final_result = {24'h0, shifted[7:0]};
    else if (pl.ld_op[0]) final_result = {{24{shifted[7]}}, shifted[7:0]};
  end

  assign mem_bus = {pl.ebus, pl.ertn, pl.csr_ctrl, pl.res_from_csr, final_result,
                    pl.rf_we, pl.rf_waddr, pl.pc};

  assign mem_bypass_bus = {pl.res_from_csr, valid & (|pl.ld_op) & ~mem_ready_go,
                           valid & pl.rf_we, pl.rf_waddr, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected WB payloads into a queue,
// a monitor pops and compares on every accepted MEM->WB handoff.
module tb_mem_stage;
  logic         clk, reset;
  logic         exe_valid, exe_ready_go;
  logic [175:0] exe_bus;
  logic         mem_allow_in;
  logic         data_ok;
  logic [31:0]  rdata;
  logic         wb_allow_in, flush;
  logic         mem_to_wb_valid, mem_ready_go;
  logic [167:0] mem_bus;
  logic [39:0]  mem_bypass_bus;
  logic         mem_ex;

  int errors = 0;
  int checks = 0;
  logic [167:0] sb[$];

  localparam logic [79:0] CSR = 80'hA5A5_0123_4567_89AB_CDEF;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .exe_ready_go(exe_ready_go), .exe_bus(exe_bus),
    .mem_allow_in(mem_allow_in),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
    .wb_allow_in(wb_allow_in), .flush(flush),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_ready_go(mem_ready_go),
    .mem_bus(mem_bus), .mem_bypass_bus(mem_bypass_bus), .mem_ex(mem_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [175:0] mk(input logic [15:0] eb, input logic er, input logic mreq,
                                      input logic [4:0] ld, input logic [1:0] alo,
                                      input logic [31:0] alu, input logic we,
                                      input logic [4:0] wa, input logic [31:0] pc);
    return {eb, er, CSR, 1'b0, mreq, ld, alo, alu, we, wa, pc};
  endfunction

  function automatic logic [167:0] ex(input logic [15:0] eb, input logic er, input logic [31:0] res,
                                      input logic we, input logic [4:0] wa, input logic [31:0] pc);
    return {eb, er, CSR, 1'b0, res, we, wa, pc};
  endfunction

  task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction into an empty MEM stage.
  task automatic issue(input string name, input logic [175:0] bus);
    #1 chk({name, "_allow"}, mem_allow_in, 1);
    exe_valid = 1'b1;
    exe_bus   = bus;
    tick();
    exe_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && mem_to_wb_valid && wb_allow_in) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got %0h expected no handoff", mem_bus);
      end else begin
        logic [167:0] e;
        e = sb.pop_front();
        if (mem_bus !== e) begin
          errors++;
          $display("FAIL wb_bus: got %0h expected %0h", mem_bus, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; exe_valid = 1'b0; exe_ready_go = 1'b1; exe_bus = '0;
    data_ok = 1'b0; rdata = '0; wb_allow_in = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_allow", mem_allow_in, 1);
    chk("rst_go", mem_ready_go, 1);
    chk("rst_wbv", mem_to_wb_valid, 0);
    chk("rst_bus", mem_bus, 0);
    chk("rst_byp", mem_bypass_bus, 0);
    chk("rst_ex", mem_ex, 0);
    tick();
    reset = 1'b1;
    tick();

    // Non-memory op: one-cycle latency, result is alu_result
    sb.push_back(ex(16'h0, 1'b0, 32'hCAFE_0001, 1'b1, 5'd7, 32'h1C00_0010));
    issue("alu", mk(16'h0, 1'b0, 1'b0, 5'b00000, 2'd0, 32'hCAFE_0001, 1'b1, 5'd7, 32'h1C00_0010));
    #1 chk("alu_wbv", mem_to_wb_valid, 1);
    chk("alu_byp_we", mem_bypass_bus[37], 1);
    tick();

    // ld.w with response in the 2nd MEM cycle
    sb.push_back(ex(16'h0, 1'b0, 32'h8000_00F0, 1'b1, 5'd3, 32'h1C00_0020));
    issue("ldw", mk(16'h0, 1'b0, 1'b1, 5'b10000, 2'd0, 32'h1111, 1'b1, 5'd3, 32'h1C00_0020));
    #1 chk("ldw_wait_wbv", mem_to_wb_valid, 0);
    chk("ldw_load_wait", mem_bypass_bus[38], 1);
    chk("ldw_wait_allow", mem_allow_in, 0);
    tick();
    data_ok = 1'b1; rdata = 32'h8000_00F0;
    #1 chk("ldw_wbv", mem_to_wb_valid, 1);
    chk("ldw_fwd", mem_bypass_bus[31:0], 32'h8000_00F0);
    tick();
    data_ok = 1'b0;

    // Sub-word loads, response in the first MEM cycle
    sb.push_back(ex(16'h0, 1'b0, 32'hFFFF_FF80, 1'b1, 5'd4, 32'h1C00_0030));
    issue("ldb", mk(16'h0, 1'b0, 1'b1, 5'b00001, 2'd3, 32'h0, 1'b1, 5'd4, 32'h1C00_0030));
    data_ok = 1'b1; rdata = 32'h8000_0000;
    #1 chk("ldb_wbv", mem_to_wb_valid, 1);
    tick(); data_ok = 1'b0;

    sb.push_back(ex(16'h0, 1'b0, 32'h0000_0080, 1'b1, 5'd4, 32'h1C00_0034));
    issue("ldbu", mk(16'h0, 1'b0, 1'b1, 5'b00010, 2'd3, 32'h0, 1'b1, 5'd4, 32'h1C00_0034));
    data_ok = 1'b1; rdata = 32'h8000_0000;
    tick(); data_ok = 1'b0;

    sb.push_back(ex(16'h0, 1'b0, 32'hFFFF_8000, 1'b1, 5'd5, 32'h1C00_0038));
    issue("ldh", mk(16'h0, 1'b0, 1'b1, 5'b00100, 2'd2, 32'h0, 1'b1, 5'd5, 32'h1C00_0038));
    data_ok = 1'b1; rdata = 32'h8000_0000;
    tick(); data_ok = 1'b0;

    sb.push_back(ex(16'h0, 1'b0, 32'h0000_9ABC, 1'b1, 5'd6, 32'h1C00_003C));
    issue("ldhu", mk(16'h0, 1'b0, 1'b1, 5'b01000, 2'd0, 32'h0, 1'b1, 5'd6, 32'h1C00_003C));
    data_ok = 1'b1; rdata = 32'h1234_9ABC;
    tick(); data_ok = 1'b0;

    sb.push_back(ex(16'h0, 1'b0, 32'h0000_007F, 1'b1, 5'd6, 32'h1C00_0040));
    issue("ldb_pos", mk(16'h0, 1'b0, 1'b1, 5'b00001, 2'd1, 32'h0, 1'b1, 5'd6, 32'h1C00_0040));
    data_ok = 1'b1; rdata = 32'h0000_7F00;
    tick(); data_ok = 1'b0;

    // Response while WB stalls: held in rbuf for 3 cycles
    sb.push_back(ex(16'h0, 1'b0, 32'h0000_1234, 1'b1, 5'd8, 32'h1C00_0050));
    issue("rbuf", mk(16'h0, 1'b0, 1'b1, 5'b10000, 2'd0, 32'h0, 1'b1, 5'd8, 32'h1C00_0050));
    wb_allow_in = 1'b0; data_ok = 1'b1; rdata = 32'h0000_1234;
    #1 chk("rbuf_allow0", mem_allow_in, 0);
    tick();
    data_ok = 1'b0; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      #1 chk("rbuf_hold_go", mem_ready_go, 1);
      chk("rbuf_hold_fwd", mem_bypass_bus[31:0], 32'h0000_1234);
      tick();
    end
    wb_allow_in = 1'b1;
    #1 chk("rbuf_rel_allow", mem_allow_in, 1);
    chk("rbuf_rel_wbv", mem_to_wb_valid, 1);
    tick();
    rdata = 32'h0;

    // Flush with request outstanding, then a new load: stale response dropped
    issue("fl_old", mk(16'h0, 1'b0, 1'b1, 5'b10000, 2'd0, 32'h0, 1'b1, 5'd9, 32'h1C00_0060));
    flush = 1'b1;
    #1 chk("fl_wbv", mem_to_wb_valid, 0);
    tick();
    flush = 1'b0;
    sb.push_back(ex(16'h0, 1'b0, 32'h0000_BEEF, 1'b1, 5'd10, 32'h1C00_0070));
    issue("fl_new", mk(16'h0, 1'b0, 1'b1, 5'b10000, 2'd0, 32'h0, 1'b1, 5'd10, 32'h1C00_0070));
    data_ok = 1'b1; rdata = 32'h0000_DEAD;
    #1 chk("fl_drop_wbv", mem_to_wb_valid, 0);
    tick();
    data_ok = 1'b0;
    #1 chk("fl_gap_go", mem_ready_go, 0);
    tick();
    data_ok = 1'b1; rdata = 32'h0000_BEEF;
    #1 chk("fl_new_wbv", mem_to_wb_valid, 1);
    tick();
    data_ok = 1'b0;

    // Address exception on a memory op: no wait, mem_ex high, ebus intact
    sb.push_back(ex(16'h0100, 1'b0, 32'h0000_1003, 1'b0, 5'd0, 32'h1C00_0080));
    issue("adem", mk(16'h0100, 1'b0, 1'b1, 5'b00000, 2'd3, 32'h0000_1003, 1'b0, 5'd0, 32'h1C00_0080));
    #1 chk("adem_go", mem_ready_go, 1);
    chk("adem_ex", mem_ex, 1);
    chk("adem_wbv", mem_to_wb_valid, 1);
    tick();
    #1 chk("adem_ex_clr", mem_ex, 0);

    // ertn raises mem_ex too
    sb.push_back(ex(16'h0, 1'b1, 32'h0, 1'b0, 5'd0, 32'h1C00_0090));
    issue("ertn", mk(16'h0, 1'b1, 1'b0, 5'b00000, 2'd0, 32'h0, 1'b0, 5'd0, 32'h1C00_0090));
    #1 chk("ertn_ex", mem_ex, 1);
    tick();

    // Async reset while a load waits with data_ok pending
    issue("rst_mid", mk(16'h0, 1'b0, 1'b1, 5'b10000, 2'd0, 32'h0, 1'b1, 5'd11, 32'h1C00_00A0));
    #1 data_ok = 1'b1; rdata = 32'h5555_AAAA; reset = 1'b0;
    #1 chk("rstm_wbv", mem_to_wb_valid, 0);
    chk("rstm_allow", mem_allow_in, 1);
    chk("rstm_bus", mem_bus, 0);
    chk("rstm_byp", mem_bypass_bus, 0);
    tick();
    data_ok = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    #1 chk("rstm_after_wbv", mem_to_wb_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
